i2c_scl_gen: RTL and testbench

- Bit-timing engine for the I2C OLED link.
- Runs in the single system clock domain produced by the PLL stage directly upstream.
- Divides that clock into I2C quarter-bit phases and drives SCL as open-drain.
- Issues one-cycle strobes for data launch, data sample and bit completion to the downstream byte/transaction controller, and supports slave clock stretching with a timeout.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_sync2.sv | 26 ++
 rtl/i2c_scl_gen.sv | 150 +++++++++++++++
 tb/tb_i2c_scl_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C bit-timing engine.
package i2c_pkg;

  typedef enum logic [2:0] {StIdle, StLow1, StLow2, StHigh1, StHigh2} scl_state_e;

  function automatic int unsigned quarter_div(input int unsigned clk_hz,
                                              input int unsigned scl_hz);
    return clk_hz / (4 * scl_hz);
  endfunction

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Generic two-flop synchronizer with selectable reset value.
module i2c_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: quarter-bit sequencing, open-drain SCL, launch/sample/done
// strobes and clock-stretch timeout.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 27000000,
  parameter int unsigned SCL_HZ      = 400000,
  parameter int unsigned QUARTER     = quarter_div(CLK_HZ, SCL_HZ),
  parameter int unsigned STRETCH_MAX = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic scl_i,
  output logic scl_oe,
  output logic busy,
  output logic launch_stb,
  output logic sample_stb,
  output logic bit_done,
  output logic err
);

  localparam int unsigned QcntW  = cnt_width(QUARTER - 1);
  localparam int unsigned StallW = cnt_width(STRETCH_MAX - 1);
  localparam logic [QcntW-1:0]  QLoad     = QcntW'(QUARTER - 1);
  localparam logic [StallW-1:0] StallLast = StallW'(STRETCH_MAX - 1);

  scl_state_e        state_q, state_d;
  logic [QcntW-1:0]  qcnt_q, qcnt_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic              scl_oe_q, busy_q, launch_q, sample_q, done_q, err_q;
  logic              launch_d, sample_d, done_d, err_d;
  logic              scl_s;

  i2c_sync2 #(
    .RESET_VAL(1'b1)
  ) u_scl_sync (
    .clk(clk),
    .rst(rst),
    .d  (scl_i),
    .q  (scl_s)
  );

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    stall_d  = stall_q;
    launch_d = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StLow1;
          qcnt_d  = QLoad;
        end
      end
      StLow1: begin
        if (qcnt_q == '0) begin
          state_d  = StLow2;
          qcnt_d   = QLoad;
          launch_d = 1'b1;
        end else begin
          qcnt_d = qcnt_q - 1'b1;
        end
      end
      StLow2: begin
        if (qcnt_q == '0) begin
          state_d = StHigh1;
          qcnt_d  = QLoad;
          stall_d = '0;
        end else begin
          qcnt_d = qcnt_q - 1'b1;
        end
      end
      StHigh1: begin
        // Only count high time the bus actually shows; a held-low SCL is a stretch.
        if (scl_s) begin
          if (qcnt_q == '0) begin
            state_d  = StHigh2;
            qcnt_d   = QLoad;
            sample_d = 1'b1;
          end else begin
            qcnt_d = qcnt_q - 1'b1;
          end
        end else if (stall_q == StallLast) begin
          state_d = StIdle;
          qcnt_d  = '0;
          stall_d = '0;
          err_d   = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      StHigh2: begin
        if (qcnt_q == '0) begin
          done_d = 1'b1;
          if (en) begin
            state_d = StLow1;
            qcnt_d  = QLoad;
          end else begin
            state_d = StIdle;
            qcnt_d  = '0;
          end
        end else begin
          qcnt_d = qcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        qcnt_d  = '0;
        stall_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so SCL drive is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      qcnt_q   <= '0;
      stall_q  <= '0;
      scl_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      launch_q <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      stall_q  <= stall_d;
      scl_oe_q <= (state_d == StLow1) || (state_d == StLow2);
      busy_q   <= (state_d != StIdle);
      launch_q <= launch_d;
      sample_q <= sample_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign scl_oe     = scl_oe_q;
  assign busy       = busy_q;
  assign launch_stb = launch_q;
  assign sample_stb = sample_q;
  assign bit_done   = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: QUARTER=16 (defaults), STRETCH_MAX=200.
module tb_i2c_scl_gen;

  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic hold_low = 1'b0;
  logic scl_i;
  logic scl_oe, busy, launch_stb, sample_stb, bit_done, err;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int viol = 0;

  int t_oe, t_rel, t_launch, t_sample, t_done, t_err, n_launch, n_sample;
  logic done_oe, done_busy;

  // Bus model: SCL follows our drive unless the bench holds it low (slave stretch).
  assign scl_i = ~scl_oe & ~hold_low;

  i2c_scl_gen #(
    .STRETCH_MAX(200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .scl_i     (scl_i),
    .scl_oe    (scl_oe),
    .busy      (busy),
    .launch_stb(launch_stb),
    .sample_stb(sample_stb),
    .bit_done  (bit_done),
    .err       (err)
  );

  always #5 if (clk_run) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones({launch_stb, sample_stb, bit_done, err}) > 1) viol++;
      if ((launch_stb || sample_stb) && !busy) viol++;
    end
  end

  // Records event cycles of one bit, starting at the current negedge.
  task automatic capture(input int budget);
    logic prev_oe;
    bit fin;
    prev_oe = 1'b0;
    fin = 1'b0;
    t_oe = -1; t_rel = -1; t_launch = -1; t_sample = -1; t_done = -1; t_err = -1;
    n_launch = 0; n_sample = 0; done_oe = 1'bx; done_busy = 1'bx;
    for (int i = 0; i < budget && !fin; i++) begin
      if (i > 0) @(negedge clk);
      if (scl_oe && !prev_oe && t_oe < 0) t_oe = cyc;
      if (!scl_oe && prev_oe && t_rel < 0) t_rel = cyc;
      if (launch_stb) begin n_launch++; if (t_launch < 0) t_launch = cyc; end
      if (sample_stb) begin n_sample++; if (t_sample < 0) t_sample = cyc; end
      if (bit_done) begin t_done = cyc; done_oe = scl_oe; done_busy = busy; fin = 1'b1; end
      if (err) begin t_err = cyc; fin = 1'b1; end
      prev_oe = scl_oe;
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({scl_oe, busy, launch_stb, sample_stb, bit_done, err} !== 6'b0)
      $display("FAIL reset_idle: outputs=%b required=000000",
               {scl_oe, busy, launch_stb, sample_stb, bit_done, err});
    else passed++;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if ({scl_oe, busy} !== 2'b11) $display("FAIL reset_prerun: oe,busy=%b required=11",
                                          {scl_oe, busy});
    else passed++;
    clk_run = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++;
    if ({scl_oe, busy, launch_stb, sample_stb, bit_done, err} !== 6'b0)
      $display("FAIL reset_async: outputs=%b required=000000",
               {scl_oe, busy, launch_stb, sample_stb, bit_done, err});
    else passed++;
    #3 rst = 1'b0;
    clk_run = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (scl_oe || busy) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL reset_stay_idle: active_cycles=%0d required=0", bad);
    else passed++;
  endtask

  task automatic test_single_bit();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    capture(200);
    total++;
    if (t_launch - t_oe !== 16) $display("FAIL single_launch: got=%0d required=16",
                                         t_launch - t_oe);
    else passed++;
    total++;
    if (t_rel - t_oe !== 32) $display("FAIL single_low_time: got=%0d required=32", t_rel - t_oe);
    else passed++;
    total++;
    if (t_sample - t_rel !== 18) $display("FAIL single_sample: got=%0d required=18",
                                          t_sample - t_rel);
    else passed++;
    total++;
    if (t_done - t_oe !== 66) $display("FAIL single_done: got=%0d required=66", t_done - t_oe);
    else passed++;
    total++;
    if ({done_oe, done_busy} !== 2'b00) $display("FAIL single_end_idle: oe,busy=%b required=00",
                                                 {done_oe, done_busy});
    else passed++;
    total++;
    if ({n_launch, n_sample} !== {32'd1, 32'd1})
      $display("FAIL single_strobe_count: launch=%0d sample=%0d required=1/1", n_launch, n_sample);
    else passed++;
    @(negedge clk);
    total++;
    if ({scl_oe, busy, bit_done} !== 3'b000)
      $display("FAIL single_after: oe,busy,done=%b required=000", {scl_oe, busy, bit_done});
    else passed++;
  endtask

  task automatic test_back_to_back();
    int td [9];
    logic toe [9];
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 9; b++) begin
      capture(200);
      td[b] = t_done;
      toe[b] = done_oe;
      if (b == 7) en = 1'b0;
      @(negedge clk);
    end
    for (int b = 1; b < 9; b++) begin
      total++;
      if (td[b] - td[b-1] !== 66)
        $display("FAIL b2b_period[%0d]: got=%0d required=66", b, td[b] - td[b-1]);
      else passed++;
    end
    for (int b = 0; b < 9; b++) begin
      total++;
      if (toe[b] !== (b < 8 ? 1'b1 : 1'b0))
        $display("FAIL b2b_reassert[%0d]: oe=%b required=%b", b, toe[b], (b < 8));
      else passed++;
    end
  endtask

  task automatic test_stretch();
    repeat (3) @(negedge clk);
    hold_low = 1'b1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    fork
      capture(400);
      begin
        for (int k = 0; k < 100 && scl_oe; k++) @(negedge clk);
        repeat (100) @(negedge clk);
        hold_low = 1'b0;
      end
    join
    total++;
    if (t_sample - t_rel !== 118) $display("FAIL stretch_sample: got=%0d required=118",
                                           t_sample - t_rel);
    else passed++;
    total++;
    if (t_done - t_oe !== 166) $display("FAIL stretch_period: got=%0d required=166",
                                        t_done - t_oe);
    else passed++;
    total++;
    if (t_err !== -1) $display("FAIL stretch_no_err: err_cycle=%0d required=none", t_err);
    else passed++;
  endtask

  task automatic test_timeout();
    repeat (3) @(negedge clk);
    hold_low = 1'b1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    capture(400);
    total++;
    if (t_err - t_rel !== 200) $display("FAIL timeout_err_time: got=%0d required=200",
                                        t_err - t_rel);
    else passed++;
    total++;
    if ({scl_oe, busy, t_done == -1} !== 3'b001)
      $display("FAIL timeout_state: oe,busy,no_done=%b required=001",
               {scl_oe, busy, t_done == -1});
    else passed++;
    @(negedge clk);
    total++;
    if ({err, busy} !== 2'b00) $display("FAIL timeout_pulse: err,busy=%b required=00",
                                        {err, busy});
    else passed++;
    hold_low = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    capture(200);
    total++;
    if (t_done - t_oe !== 66) $display("FAIL timeout_recover: got=%0d required=66",
                                       t_done - t_oe);
    else passed++;
  endtask

  task automatic test_en_drop();
    int bad;
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    fork
      capture(200);
      begin
        repeat (20) @(negedge clk);
        en = 1'b0;
      end
    join
    total++;
    if (t_done - t_oe !== 66) $display("FAIL endrop_done: got=%0d required=66", t_done - t_oe);
    else passed++;
    total++;
    if ({done_oe, done_busy} !== 2'b00) $display("FAIL endrop_idle: oe,busy=%b required=00",
                                                 {done_oe, done_busy});
    else passed++;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (scl_oe || busy) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL endrop_no_restart: active_cycles=%0d required=0", bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_back_to_back();
    test_stretch();
    test_timeout();
    test_en_drop();
    total++;
    if (viol !== 0) $display("FAIL strobe_exclusive: violations=%0d required=0", viol);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
